// File: rtl/bt_clear_seq_if.sv
// Clear/randomness handshake between the BT alarm logic, the clear sequencer and
// the masked register bank.
interface bt_clear_seq_if #(
  parameter int COUNT = 64
);
  logic             req;
  logic             reseed_valid;
  logic [31:0]      reseed_data;
  logic             clear;
  logic [COUNT-1:0] rnd;
  logic             busy;
  logic             done;

  modport master (
    output req, reseed_valid, reseed_data,
    input  clear, rnd, busy, done
  );

  modport slave (
    input  req, reseed_valid, reseed_data,
    output clear, rnd, busy, done
  );
endinterface

// File: rtl/bt_clear_seq.sv
// Clear sequencer for Borrowed-Time masked registers: issues clear bursts with a
// continuously refreshed random pool fed by a 32-bit Galois LFSR.
module bt_clear_seq #(
  parameter int          COUNT        = 64,
  parameter int          CLEAR_CYCLES = 2,
  parameter logic [31:0] SEED         = 32'h0000_0001
) (
  input  logic          clk,
  input  logic          rst_n,
  bt_clear_seq_if.slave bus
);

  localparam int              CNT_W    = 16;
  localparam logic [CNT_W-1:0] WARM_LEN = CNT_W'(COUNT / 32);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {WARM, IDLE, CLEAR, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [COUNT-1:0]   pool_q, pool_d;
  logic               pend_q, pend_d;
  logic               clear_q, clear_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Pool and LFSR are reset too: rnd must read 0 and the sequence restart at SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WARM;
      cnt_q   <= WARM_LEN;
      lfsr_q  <= SEED;
      pool_q  <= '0;
      pend_q  <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      pool_q  <= pool_d;
      pend_q  <= pend_d;
      clear_q <= clear_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    lfsr_d  = lfsr_step(lfsr_q);
    pool_d  = {pool_q[COUNT-33:0], lfsr_q};

    if (bus.req && state_q != IDLE) pend_d = 1'b1;

    unique case (state_q)
      WARM: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q <= ONE) state_d = IDLE;
      end
      IDLE: begin
        // A simultaneous request is parked so it survives the warm-up.
        if (bus.reseed_valid) begin
          lfsr_d  = (bus.reseed_data == 32'h0) ? SEED : bus.reseed_data;
          state_d = WARM;
          cnt_d   = WARM_LEN;
          if (bus.req) pend_d = 1'b1;
        end else if (bus.req || pend_q) begin
          state_d = CLEAR;
          cnt_d   = CLR_LAST;
          pend_d  = 1'b0;
        end
      end
      CLEAR: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - ONE;
      end
      DONE: begin
        if (pend_q || bus.req) begin
          state_d = CLEAR;
          cnt_d   = CLR_LAST;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    clear_d = (state_d == CLEAR);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  assign bus.clear = clear_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.rnd   = pool_q;

endmodule

// File: tb/tb_bt_clear_seq.sv
// Directed bench for bt_clear_seq with a reference LFSR/pool model.
module tb_bt_clear_seq;

  localparam int          COUNT = 64;
  localparam logic [31:0] SEED  = 32'h0000_0001;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  bt_clear_seq_if #(.COUNT(COUNT)) bus ();

  bt_clear_seq #(.COUNT(COUNT), .CLEAR_CYCLES(2), .SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: reseeds are applied only when the stimulus knows they are honoured.
  logic [31:0]      m_lfsr;
  logic [COUNT-1:0] m_pool;
  logic             m_take;
  logic [31:0]      m_seed;

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= SEED;
      m_pool <= '0;
    end else begin
      m_pool <= {m_pool[COUNT-33:0], m_lfsr};
      m_lfsr <= m_take ? m_seed : ref_next(m_lfsr);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic record(input int n, output logic [15:0] cv, output logic [15:0] dv);
    cv = '0;
    dv = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      cv[i] = bus.clear;
      dv[i] = bus.done;
      check_val("rnd_vs_model", bus.rnd, m_pool);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0]      cv, dv;
    logic [COUNT-1:0] r0;
    int               waited;
    bit               found;

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    m_take = 1'b0;
    m_seed = SEED;
    bus.req = 1'b0;
    bus.reseed_valid = 1'b0;
    bus.reseed_data = 32'h0;

    repeat (3) @(negedge clk);
    check_val("rst_busy",  bus.busy,  1);
    check_val("rst_clear", bus.clear, 0);
    check_val("rst_done",  bus.done,  0);
    check_val("rst_rnd",   bus.rnd,   0);

    // Warm-up after reset release
    rst_n = 1'b1;
    tick();
    check_val("warm_busy1", bus.busy, 1);
    tick();
    check_val("warm_rnd2", bus.rnd, 64'h00000001_80200003);
    check_val("warm_busy2", bus.busy, 0);
    tick();
    check_val("warm_rnd3_lo", bus.rnd[31:0], 32'hC0300002);
    check_val("warm_rnd3_model", bus.rnd, m_pool);

    // Single request pulse
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    check_val("sgl_clear0", bus.clear, 1);
    check_val("sgl_busy0", bus.busy, 1);
    r0 = bus.rnd;
    tick();
    check_val("sgl_clear1", bus.clear, 1);
    check_val("sgl_rnd_changes", (bus.rnd != r0), 1);
    tick();
    check_val("sgl_clear2", bus.clear, 0);
    check_val("sgl_done", bus.done, 1);
    tick();
    check_val("sgl_done_end", bus.done, 0);
    check_val("sgl_busy_end", bus.busy, 0);

    // One extra request during CLEAR gives one back-to-back burst
    bus.req = 1'b1;
    record(2, cv, dv);
    bus.req = 1'b0;
    check_val("b2b_head_clr", cv[1:0], 2'b11);
    record(8, cv, dv);
    check_val("b2b_clr_pat", cv[7:0], 8'b0000_0110);
    check_val("b2b_done_pat", dv[7:0], 8'b0000_1001);
    check_val("b2b_busy_end", bus.busy, 0);

    // Three extra requests (CLEAR, CLEAR, DONE) collapse into one burst
    bus.req = 1'b1;
    record(4, cv, dv);
    bus.req = 1'b0;
    check_val("tri_head_clr", cv[3:0], 4'b1011);
    check_val("tri_head_done", dv[3:0], 4'b0100);
    record(8, cv, dv);
    check_val("tri_clr_pat", cv[7:0], 8'b0000_0001);
    check_val("tri_done_pat", dv[7:0], 8'b0000_0010);
    check_val("tri_busy_end", bus.busy, 0);

    // Zero reseed together with a request in IDLE
    bus.reseed_valid = 1'b1;
    bus.reseed_data = 32'h0;
    bus.req = 1'b1;
    m_take = 1'b1;
    m_seed = SEED;
    tick();
    bus.reseed_valid = 1'b0;
    bus.req = 1'b0;
    m_take = 1'b0;
    check_val("rsd_busy", bus.busy, 1);
    check_val("rsd_clear", bus.clear, 0);
    tick();
    check_val("rsd_seed_in_pool", bus.rnd[31:0], 32'h0000_0001);
    check_val("rsd_busy_warm2", bus.busy, 1);
    found = 1'b0;
    waited = 0;
    while (!found && waited < 8) begin
      tick();
      waited++;
      check_val("rsd_rnd_vs_model", bus.rnd, m_pool);
      if (bus.clear) found = 1'b1;
    end
    check_val("rsd_burst_seen", found, 1);
    record(2, cv, dv);
    check_val("rsd_burst_clr", cv[1:0], 2'b01);
    check_val("rsd_burst_done", dv[1:0], 2'b10);
    record(2, cv, dv);
    check_val("rsd_busy_end", bus.busy, 0);

    // Asynchronous reset in the middle of a burst, with a request pending
    bus.req = 1'b1;
    tick();
    bus.req = 1'b1;
    @(posedge clk);
    #2;
    bus.req = 1'b0;
    check_val("arst_pre_clear", bus.clear, 1);
    rst_n = 1'b0;
    #1;
    check_val("arst_clear_async", bus.clear, 0);
    check_val("arst_busy", bus.busy, 1);
    check_val("arst_done", bus.done, 0);
    check_val("arst_rnd", bus.rnd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    record(6, cv, dv);
    check_val("arst_no_pending_clr", cv[5:0], 6'b0);
    check_val("arst_no_pending_done", dv[5:0], 6'b0);
    check_val("arst_busy_end", bus.busy, 0);

    // Reseed during CLEAR is dropped
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    bus.reseed_valid = 1'b1;
    bus.reseed_data = 32'h1234_5678;
    tick();
    bus.reseed_valid = 1'b0;
    check_val("ign_clear", bus.clear, 1);
    record(8, cv, dv);
    check_val("ign_done_pat", dv[7:0], 8'b0000_0001);
    check_val("ign_clr_pat", cv[7:0], 8'b0);
    check_val("ign_busy_end", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
